// File: rtl/jtpang_fmq_pkg.sv
// Shared types and constants for the OPLL write queue.
// Optional statistics build: define JTPANG_FMQ_STATS_EN.
package jtpang_fmq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AWR,
    ST_AWT,
    ST_DWR,
    ST_DWT
  } fmq_state_t;

  localparam int ADDR_WAIT_DEF = 12;
  localparam int DATA_WAIT_DEF = 84;
  localparam int WCNT_W        = 7;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } fmq_pair_t;

endpackage

// File: rtl/jtpang_fmq_fifo.sv
// DEPTH x 16 pair FIFO with wrap-bit pointers, registered read and sticky overflow.
// JTPANG_FMQ_STATS_EN adds a saturating drop counter and a high-water mark.
module jtpang_fmq_fifo
  import jtpang_fmq_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic [15:0] push_data,
  input  logic        pop,
  output logic [15:0] pop_data,
  output logic        full,
  output logic        empty,
  output logic        overflow
`ifdef JTPANG_FMQ_STATS_EN
  ,
  output logic [7:0]  drop_cnt,
  output logic [AW:0] max_fill
`endif
);

  fmq_pair_t   mem [DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic        do_push;
  logic        do_pop;

  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty   = (wptr == rptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      if (push && full) overflow <= 1'b1;
    end
  end

  // Storage carries no reset so it maps onto block RAM; the read register is the hold.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= fmq_pair_t'(push_data);
    if (do_pop)  pop_data          <= mem[rptr[AW-1:0]];
  end

`ifdef JTPANG_FMQ_STATS_EN
  logic [AW:0] level;
  assign level = wptr - rptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
      max_fill <= '0;
    end else begin
      if (push && full && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
      if (level > max_fill) max_fill <= level;
    end
  end
`endif

endmodule

// File: rtl/jtpang_fmq.sv
// OPLL write-side bus initiator: queued (addr,data) pairs become timed strobes.
// Optional statistics ports appear when JTPANG_FMQ_STATS_EN is defined.
module jtpang_fmq
  import jtpang_fmq_pkg::*;
#(
  parameter  int DEPTH     = 16,
  parameter  int ADDR_WAIT = ADDR_WAIT_DEF,
  parameter  int DATA_WAIT = DATA_WAIT_DEF,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fm_cen,
  input  logic        wr,
  input  logic [7:0]  wr_addr,
  input  logic [7:0]  wr_data,
  output logic        full,
  output logic        empty,
  output logic        busy,
  output logic        overflow,
  output logic [7:0]  fm_dout,
  output logic        fm_a0,
  output logic        fm_cs,
  output logic        fm_wr_n
`ifdef JTPANG_FMQ_STATS_EN
  ,
  output logic [7:0]  drop_cnt,
  output logic [AW:0] max_fill
`endif
);

  localparam logic [WCNT_W-1:0] ADDR_LAST = (WCNT_W)'(ADDR_WAIT - 1);
  localparam logic [WCNT_W-1:0] DATA_LAST = (WCNT_W)'(DATA_WAIT - 1);

  fmq_state_t        state;
  logic [WCNT_W-1:0] wcnt;
  logic              pop;
  logic [15:0]       pop_data;
  fmq_pair_t         hold;

  assign pop  = (state == ST_IDLE) && !empty;
  assign hold = fmq_pair_t'(pop_data);
  assign busy = (state != ST_IDLE);

  jtpang_fmq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (wr),
    .push_data ({wr_addr, wr_data}),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow)
`ifdef JTPANG_FMQ_STATS_EN
    ,
    .drop_cnt  (drop_cnt),
    .max_fill  (max_fill)
`endif
  );

  // A strobe only ends on a cen tick seen while fm_cs was already high, so the
  // FM core always samples the strobe asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      wcnt    <= '0;
      fm_cs   <= 1'b0;
      fm_wr_n <= 1'b1;
      fm_a0   <= 1'b0;
      fm_dout <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!empty) state <= ST_AWR;
        end
        ST_AWR: begin
          if (fm_cs && fm_cen) begin
            fm_cs   <= 1'b0;
            fm_wr_n <= 1'b1;
            wcnt    <= '0;
            state   <= ST_AWT;
          end else begin
            fm_cs   <= 1'b1;
            fm_wr_n <= 1'b0;
            fm_a0   <= 1'b0;
            fm_dout <= hold.addr;
          end
        end
        ST_AWT: begin
          if (fm_cen) begin
            if (wcnt == ADDR_LAST) begin
              wcnt  <= '0;
              state <= ST_DWR;
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end
        end
        ST_DWR: begin
          if (fm_cs && fm_cen) begin
            fm_cs   <= 1'b0;
            fm_wr_n <= 1'b1;
            wcnt    <= '0;
            state   <= ST_DWT;
          end else begin
            fm_cs   <= 1'b1;
            fm_wr_n <= 1'b0;
            fm_a0   <= 1'b1;
            fm_dout <= hold.data;
          end
        end
        ST_DWT: begin
          if (fm_cen) begin
            if (wcnt == DATA_LAST) begin
              wcnt  <= '0;
              state <= ST_IDLE;
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
